// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder/subtractor: one 4-bit carry-lookahead slice reused per nibble, LSB first.
// Define NIBBLE_SERIAL_ADDER_FLAGS_EN to build the {N,Z,C,V} flag logic; otherwise flags read 4'b0000.

module nibble_cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       pg_o,
  output logic       gg_o
);
  logic [3:0] p, g, c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);

  assign s_o  = p ^ c;
  assign pg_o = &p;
  assign gg_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 64  // multiple of 4, at least 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam int MSB     = WIDTH - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             fin_q, fin_d;

  logic [3:0] nib_a, nib_b, nib_s;
  logic       pg, gg;

  assign nib_a = a_q[{idx_q, 2'b00} +: 4];
  assign nib_b = b_q[{idx_q, 2'b00} +: 4];

  nibble_cla4 u_slice (
    .a_i  (nib_a),
    .b_i  (nib_b),
    .c_i  (carry_q),
    .s_o  (nib_s),
    .pg_o (pg),
    .gg_o (gg)
  );

  // fin_q marks that the last nibble is written; the following RUN cycle
  // settles the flags from the complete result and moves to DONE.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    fin_d    = fin_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = RUN;
          a_d      = a;
          b_d      = sub ? ~b : b;
          carry_d  = sub;
          idx_d    = '0;
          fin_d    = 1'b0;
          result_d = '0;
        end
      end
      RUN: begin
        if (fin_q) begin
          state_d = DONE;
        end else begin
          result_d[{idx_q, 2'b00} +: 4] = nib_s;
          carry_d = gg | (pg & carry_q);
          if (idx_q == LAST_IDX) fin_d = 1'b1;
          else                   idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: operand registers are reset too, so post-reset state is fully defined.
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      fin_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      fin_q    <= fin_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
  logic [3:0] flags_q, flags_d;

  // b_q already holds the operand actually added, so V compares against it directly.
  always_comb begin
    flags_d = flags_q;
    if (state_q == RUN && fin_q) begin
      flags_d = {result_q[MSB], (result_q == '0), carry_q,
                 (a_q[MSB] == b_q[MSB]) && (result_q[MSB] != a_q[MSB])};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

  assign flags = flags_q;
`else
  assign flags = 4'b0000;
`endif
endmodule
